// File: rtl/logic_serial.sv
// Bit-serial 8-bit logic unit: one result bit per clock, LSB first, through a
// single one-bit cell; bit-identical to the parallel AND/OR/XOR/NOT unit.
module logic_serial (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] A,
    input  logic [7:0] B,
    input  logic       s1,
    input  logic       s0,
    output logic [7:0] D,
    output logic       busy,
    output logic       done
);

    localparam int unsigned W    = 8;
    localparam int unsigned CW   = 3;
    localparam int unsigned OPW  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [W-1:0]   a_sh, a_nx;
    logic [W-1:0]   b_sh, b_nx;
    logic [W-1:0]   d_sh, d_nx;
    logic [W-1:0]   dq_nx;
    logic [OPW-1:0] op, op_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic           busy_nx, done_nx;
    logic           bit_c;

    // One-bit logic cell shared by all eight bit positions
    always_comb begin
        bit_c = 1'b0;
        unique case (op)
            2'b00:   bit_c = a_sh[0] & b_sh[0];
            2'b01:   bit_c = a_sh[0] | b_sh[0];
            2'b10:   bit_c = a_sh[0] ^ b_sh[0];
            default: bit_c = ~a_sh[0];
        endcase
    end

    // Next-state and datapath update
    always_comb begin
        state_nx = state;
        a_nx     = a_sh;
        b_nx     = b_sh;
        d_nx     = d_sh;
        dq_nx    = D;
        op_nx    = op;
        cnt_nx   = cnt;

        case (state)
            IDLE: begin
                if (start) begin
                    a_nx     = A;
                    b_nx     = B;
                    op_nx    = {s1, s0};
                    cnt_nx   = CW'(0);
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                d_nx   = {bit_c, d_sh[W-1:1]};
                a_nx   = a_sh >> 1;
                b_nx   = b_sh >> 1;
                cnt_nx = cnt + CW'(1);
                if (cnt == CW'(W - 1)) begin
                    dq_nx    = {bit_c, d_sh[W-1:1]};
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx == SHIFT);
        done_nx = (state_nx == DONE);
    end

    // State and datapath registers; busy/done track the registered state
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            d_sh  <= '0;
            op    <= '0;
            cnt   <= '0;
            D     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            a_sh  <= a_nx;
            b_sh  <= b_nx;
            d_sh  <= d_nx;
            op    <= op_nx;
            cnt   <= cnt_nx;
            D     <= dq_nx;
            busy  <= busy_nx;
            done  <= done_nx;
        end
    end

endmodule

// File: tb/tb_logic_serial.sv
// Directed bench for logic_serial: fixed vectors, in-flight changes, ignored
// restarts, mid-op reset, back-to-back starts and random vectors vs a model.
module tb_logic_serial;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] A, B;
    logic       s1, s0;
    logic [7:0] D;
    logic       busy, done;

    int total = 0;
    int bad   = 0;

    logic [7:0] ra, rb;
    logic [1:0] rop;
    int         dcnt, bcnt;
    int         dpos [3];

    logic_serial dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .s1    (s1),
        .s0    (s0),
        .D     (D),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] plu(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] o);
        case (o)
            2'b00:   return a & b;
            2'b01:   return a | b;
            2'b10:   return a ^ b;
            default: return ~a;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one op and watch 11 cycles from the start edge.
    // scramble: change inputs every cycle in flight; restart: pulse start 3 cycles in.
    task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] o, input bit scramble, input bit restart,
                         input bit verbose);
        logic [7:0] exp, d_before, dval;
        int nb, nd, dp, held;
        exp      = plu(a, b, o);
        d_before = D;
        A = a; B = b; {s1, s0} = o; start = 1'b1;
        tick();
        start = 1'b0;
        nb = 0; nd = 0; dp = -1; held = 1; dval = 8'h00;
        for (int i = 0; i < 11; i++) begin
            if (busy) nb++;
            if (done) begin nd++; dp = i; dval = D; end
            if (i < 8 && D !== d_before) held = 0;
            if (scramble) begin
                A = 8'($urandom); B = 8'($urandom); {s1, s0} = 2'($urandom);
            end
            start = (restart && i == 2);
            tick();
        end
        start = 1'b0;
        if (verbose) begin
            check({tag, "_busy_cycles"}, 32'(nb), 32'd8);
            check({tag, "_done_count"}, 32'(nd), 32'd1);
            check({tag, "_done_pos"}, 32'(dp), 32'd8);
            check({tag, "_d_held"}, 32'(held), 32'd1);
        end
        check({tag, "_d_at_done"}, 32'(dval), 32'(exp));
        check({tag, "_d_after"}, 32'(D), 32'(exp));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; s1 = 1'b0; s0 = 1'b0;
        tick(); tick();
        check("reset_d", 32'(D), 32'h00);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        rst = 1'b0;
        tick();

        do_op("and", 8'hCA, 8'h5F, 2'b00, 1'b0, 1'b0, 1'b1);
        do_op("or",  8'hCA, 8'h5F, 2'b01, 1'b0, 1'b0, 1'b1);
        do_op("xor", 8'hCA, 8'h5F, 2'b10, 1'b0, 1'b0, 1'b1);
        do_op("not", 8'hCA, 8'h5F, 2'b11, 1'b0, 1'b0, 1'b1);
        check("not_value", 32'(D), 32'h35);

        do_op("inflight", 8'hFF, 8'h00, 2'b10, 1'b1, 1'b0, 1'b1);
        check("inflight_value", 32'(D), 32'hFF);

        do_op("restart", 8'h3C, 8'hA5, 2'b01, 1'b0, 1'b1, 1'b1);
        bcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy || done) bcnt++;
            tick();
        end
        check("restart_no_rebusy", 32'(bcnt), 32'd0);

        // Reset at the 4th SHIFT cycle of an op following a completed AND
        do_op("pre_rst", 8'hCA, 8'h5F, 2'b00, 1'b0, 1'b0, 1'b0);
        check("pre_rst_value", 32'(D), 32'h4A);
        A = 8'h12; B = 8'h34; {s1, s0} = 2'b01; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_d", 32'(D), 32'h00);
        dcnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done || busy) dcnt++;
            tick();
        end
        check("rst_no_done", 32'(dcnt), 32'd0);
        check("rst_d_stays", 32'(D), 32'h00);

        // start held high for 30 cycles
        A = 8'h96; B = 8'h0F; {s1, s0} = 2'b10; start = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) begin
                if (dcnt < 3) dpos[dcnt] = i;
                dcnt++;
                check("cont_d", 32'(D), 32'h99);
            end
            if (i == 29) start = 1'b0;
        end
        check("cont_done_count", 32'(dcnt), 32'd3);
        if (dcnt == 3) begin
            check("cont_first", 32'(dpos[0]), 32'd8);
            check("cont_gap1", 32'(dpos[1] - dpos[0]), 32'd10);
            check("cont_gap2", 32'(dpos[2] - dpos[1]), 32'd10);
        end
        tick(); tick();
        check("cont_idle", 32'(busy), 32'd0);

        for (int n = 0; n < 256; n++) begin
            ra = 8'($urandom); rb = 8'($urandom); rop = 2'($urandom);
            do_op("rand", ra, rb, rop, 1'b0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
